// File: rtl/net_route_pkg.sv
// Route unit shared types: route codes, dest-field extraction and ring shortest-path routing.
// Purely combinational helpers; no latency, no flow control.
// Helpers work at fixed maximum widths, so callers zero-extend their operands into them.
package net_route_pkg;

    typedef logic [1:0] route_t;

    localparam route_t ROUTE_TERM = 2'd0;
    localparam route_t ROUTE_CW   = 2'd1;
    localparam route_t ROUTE_CCW  = 2'd2;

    localparam int DEST_MAX = 16;
    localparam int MSG_MAX  = 512;

    function automatic logic [DEST_MAX-1:0] get_dest(
        input logic [MSG_MAX-1:0] msg,
        input int unsigned        lsb
    );
        return DEST_MAX'(msg >> lsb);
    endfunction

    // tie_sel picks the direction when dest is exactly half-way round an even ring
    function automatic route_t route_compute(
        input logic [DEST_MAX-1:0] dest,
        input logic [DEST_MAX-1:0] id,
        input logic [DEST_MAX-1:0] n,
        input logic                tie_sel
    );
        logic [DEST_MAX:0]   d;
        logic [DEST_MAX+1:0] d2;
        logic [DEST_MAX+1:0] n2;
        route_t              r;
        d = {1'b0, dest} - {1'b0, id};
        if (d[DEST_MAX]) begin
            d = d + {1'b0, n};
        end
        d2 = {d, 1'b0};
        n2 = {2'b00, n};
        if (dest >= n) begin
            r = ROUTE_TERM;
        end else if (d == '0) begin
            r = ROUTE_TERM;
        end else if (d2 < n2) begin
            r = ROUTE_CW;
        end else if (d2 > n2) begin
            r = ROUTE_CCW;
        end else begin
            r = tie_sel ? ROUTE_CCW : ROUTE_CW;
        end
        return r;
    endfunction

endpackage

// File: rtl/net_route_buf2.sv
// Generic 2-entry FIFO with registered enq_rdy and register-sourced dequeue side.
// Latency: an entry written at edge t is presented on deq_dat from t onward.
// Backpressure: enq_rdy = occupancy < 2, registered; no combinational path from deq_rdy.
module net_route_buf2 #(
    parameter int p_width = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [p_width-1:0] enq_dat,
    input  logic               enq_vld,
    output logic               enq_rdy,
    output logic [p_width-1:0] deq_dat,
    output logic               deq_vld,
    input  logic               deq_rdy
);

    logic [p_width-1:0] r_ent0;
    logic [p_width-1:0] r_ent1;
    logic               r_wptr;
    logic               r_rptr;
    logic [1:0]         r_cnt;
    logic               r_rdy;
    logic               w_enq;
    logic               w_deq;
    logic [1:0]         w_cnt_nxt;

    assign w_enq   = enq_vld && r_rdy;
    assign deq_vld = (r_cnt != 2'd0);
    assign w_deq   = deq_vld && deq_rdy;
    assign enq_rdy = r_rdy;
    assign deq_dat = r_rptr ? r_ent1 : r_ent0;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_enq && !w_deq) begin
            w_cnt_nxt = r_cnt + 2'd1;
        end else if (!w_enq && w_deq) begin
            w_cnt_nxt = r_cnt - 2'd1;
        end
    end

    // r_rdy resets low so the upstream sees not-ready until the first edge after reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ent0 <= '0;
            r_ent1 <= '0;
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_cnt  <= 2'd0;
            r_rdy  <= 1'b0;
        end else begin
            if (w_enq) begin
                if (r_wptr) begin
                    r_ent1 <= enq_dat;
                end else begin
                    r_ent0 <= enq_dat;
                end
                r_wptr <= ~r_wptr;
            end
            if (w_deq) begin
                r_rptr <= ~r_rptr;
            end
            r_cnt <= w_cnt_nxt;
            r_rdy <= (w_cnt_nxt != 2'd2);
        end
    end

endmodule

// File: rtl/net_router_route_unit_ring.sv
// Ring route unit: steers each message to terminal/cw/ccw by shortest path; NET_ROUTE_TIE_ALT_EN alternates ties.
// Latency: 1 cycle minimum (visible on its ostream the cycle after acceptance), in-order delivery.
// Backpressure: 2-entry buffer, istream_rdy registered, head-of-line blocking on the head's output.
module net_router_route_unit_ring
    import net_route_pkg::*;
#(
    parameter int p_msg_nbits   = 44,
    parameter int p_num_routers = 4,
    parameter int p_dest_nbits  = 2,
    parameter int p_dest_lsb    = 36
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [p_dest_nbits-1:0]     router_id,
    input  logic [p_msg_nbits-1:0]      istream_msg,
    input  logic                        istream_val,
    output logic                        istream_rdy,
    output logic [2:0][p_msg_nbits-1:0] ostream_msg,
    output logic [2:0]                  ostream_val,
    input  logic [2:0]                  ostream_rdy
);

    logic [p_dest_nbits-1:0] w_dest;
    route_t                  w_route_cw;
    route_t                  w_route_alt;
    route_t                  w_route;
    logic                    w_tie_sel;
    logic                    w_enq;
    logic [p_msg_nbits+1:0]  w_head;
    logic [p_msg_nbits-1:0]  w_head_msg;
    route_t                  w_head_route;
    logic                    w_head_vld;
    logic                    w_deq;

    assign w_dest = p_dest_nbits'(get_dest(MSG_MAX'(istream_msg), p_dest_lsb));

    // Two evaluations differ only for a tie, which also gives tie detection for free
    assign w_route_cw  = route_compute(DEST_MAX'(w_dest), DEST_MAX'(router_id),
                                       DEST_MAX'(p_num_routers), 1'b0);
    assign w_route_alt = route_compute(DEST_MAX'(w_dest), DEST_MAX'(router_id),
                                       DEST_MAX'(p_num_routers), 1'b1);
    assign w_route     = w_tie_sel ? w_route_alt : w_route_cw;
    assign w_enq       = istream_val && istream_rdy;

`ifdef NET_ROUTE_TIE_ALT_EN
    logic r_tie_tgl;
    logic w_is_tie;

    assign w_is_tie  = (w_route_cw != w_route_alt);
    assign w_tie_sel = r_tie_tgl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tie_tgl <= 1'b0;
        end else if (w_enq && w_is_tie) begin
            r_tie_tgl <= ~r_tie_tgl;
        end
    end
`else
    assign w_tie_sel = 1'b0;
`endif

    net_route_buf2 #(
        .p_width (p_msg_nbits + 2)
    ) u_buf (
        .clk     (clk),
        .reset_n (reset_n),
        .enq_dat ({w_route, istream_msg}),
        .enq_vld (istream_val),
        .enq_rdy (istream_rdy),
        .deq_dat (w_head),
        .deq_vld (w_head_vld),
        .deq_rdy (w_deq)
    );

    assign w_head_msg   = w_head[p_msg_nbits-1:0];
    assign w_head_route = w_head[p_msg_nbits +: 2];
    assign w_deq        = |(ostream_val & ostream_rdy);

    always_comb begin
        ostream_val = '0;
        ostream_msg = '0;
        for (int k = 0; k < 3; k++) begin
            if (w_head_vld && (w_head_route == route_t'(k))) begin
                ostream_val[k] = 1'b1;
                ostream_msg[k] = w_head_msg;
            end
        end
    end

endmodule

// File: tb/tb_net_router_route_unit_ring.sv
// Directed bench for the ring route unit: an N=8/id=2 instance and an N=5/id=4 instance on shared stimulus.
// Expected routes are hand-computed from the ring distance d = (dest - id) mod N.
module tb_net_router_route_unit_ring;

    localparam int MW = 44;
    typedef logic [3*MW-1:0] wide_t;

`ifdef NET_ROUTE_TIE_ALT_EN
    localparam int TIE_R1 = 2;
`else
    localparam int TIE_R1 = 1;
`endif

    // dest 6 (tie) excluded from full-rate traffic so the toggle does not matter there
    localparam int FR_D[7] = '{0, 1, 2, 3, 4, 5, 7};
    localparam int FR_R[7] = '{2, 2, 0, 1, 1, 1, 2};

    logic                clk = 1'b0;
    logic                reset_n;
    logic [MW-1:0]       istream_msg;
    logic                istream_val;
    logic [2:0]          ostream_rdy;
    logic                rdy8;
    logic                rdy5;
    logic [2:0][MW-1:0]  om8;
    logic [2:0][MW-1:0]  om5;
    logic [2:0]          ov8;
    logic [2:0]          ov5;
    int                  n_cmp = 0;
    int                  n_bad = 0;

    always #5 clk = ~clk;

    net_router_route_unit_ring #(
        .p_msg_nbits (MW), .p_num_routers (8), .p_dest_nbits (3), .p_dest_lsb (36)
    ) u8 (
        .clk (clk), .reset_n (reset_n), .router_id (3'd2),
        .istream_msg (istream_msg), .istream_val (istream_val), .istream_rdy (rdy8),
        .ostream_msg (om8), .ostream_val (ov8), .ostream_rdy (ostream_rdy)
    );

    net_router_route_unit_ring #(
        .p_msg_nbits (MW), .p_num_routers (5), .p_dest_nbits (3), .p_dest_lsb (36)
    ) u5 (
        .clk (clk), .reset_n (reset_n), .router_id (3'd4),
        .istream_msg (istream_msg), .istream_val (istream_val), .istream_rdy (rdy5),
        .ostream_msg (om5), .ostream_val (ov5), .ostream_rdy (ostream_rdy)
    );

    function automatic logic [MW-1:0] mk(input int dest, input int t);
        logic [2:0] d3;
        logic [7:0] t8;
        d3 = 3'(dest);
        t8 = 8'(t);
        return {5'b0, d3, 28'h0, t8};
    endfunction

    task automatic chk(input string tag, input wide_t obs, input wide_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic headx(input string tag, input logic [2:0] ov, input logic [2:0][MW-1:0] om,
                         input logic [MW-1:0] m, input int r);
        logic [2:0]         ev;
        logic [2:0][MW-1:0] em;
        ev    = '0;
        em    = '0;
        ev[r] = 1'b1;
        em[r] = m;
        chk({tag, "_val"}, wide_t'(ov), wide_t'(ev));
        chk({tag, "_msg"}, wide_t'(om), wide_t'(em));
    endtask

    task automatic empty8(input string tag);
        chk({tag, "_val"}, wide_t'(ov8), wide_t'(3'b000));
        chk({tag, "_msg"}, wide_t'(om8), wide_t'(0));
    endtask

    // Present one message, expect it accepted at the next edge and shown as head right after
    task automatic send(input string tag, input int dest, input int t, input int r, input bit on5);
        logic [MW-1:0] m;
        m           = mk(dest, t);
        istream_msg = m;
        istream_val = 1'b1;
        chk({tag, "_rdy"}, wide_t'(on5 ? rdy5 : rdy8), wide_t'(1'b1));
        tick();
        if (on5) headx(tag, ov5, om5, m, r);
        else     headx(tag, ov8, om8, m, r);
    endtask

    initial begin
        logic [MW-1:0] m1, m2, m3, m4;
        reset_n     = 1'b0;
        istream_msg = '0;
        istream_val = 1'b0;
        ostream_rdy = 3'b111;
        repeat (2) tick();
        chk("rst_rdy", wide_t'(rdy8), wide_t'(1'b0));
        empty8("rst_out");
        reset_n = 1'b1;
        #1;
        chk("rel_rdy_before_edge", wide_t'(rdy8), wide_t'(1'b0));
        tick();
        chk("rel_rdy_after_edge", wide_t'(rdy8), wide_t'(1'b1));

        // Basic routing, back-to-back: d=0 term, d=3 cw, d=5 ccw
        send("basic_d2", 2, 1, 0, 1'b0);
        send("basic_d5", 5, 2, 1, 1'b0);
        send("basic_d7", 7, 3, 2, 1'b0);
        istream_val = 1'b0;
        tick();
        empty8("basic_drain");

        // Ties: d=4 on N=8
        send("tie_0", 6, 10, 1, 1'b0);
        send("tie_1", 6, 11, TIE_R1, 1'b0);
        send("tie_2", 6, 12, 1, 1'b0);
        istream_val = 1'b0;
        tick();
        empty8("tie_drain");

        // Backpressure on the clockwise port, dest 4 (d=2 -> cw)
        m1 = mk(4, 40); m2 = mk(4, 41); m3 = mk(4, 42); m4 = mk(4, 43);
        ostream_rdy = 3'b101;
        istream_msg = m1; istream_val = 1'b1;
        tick();
        chk("bp_rdy_1", wide_t'(rdy8), wide_t'(1'b1));
        headx("bp_head_1", ov8, om8, m1, 1);
        istream_msg = m2;
        tick();
        chk("bp_rdy_full", wide_t'(rdy8), wide_t'(1'b0));
        headx("bp_head_full", ov8, om8, m1, 1);
        istream_msg = m3;
        tick();
        chk("bp_rdy_stall", wide_t'(rdy8), wide_t'(1'b0));
        headx("bp_head_stall", ov8, om8, m1, 1);
        ostream_rdy = 3'b111;
        tick();
        chk("bp_rdy_return", wide_t'(rdy8), wide_t'(1'b1));
        headx("bp_drain_2", ov8, om8, m2, 1);
        tick();
        headx("bp_drain_3", ov8, om8, m3, 1);
        istream_msg = m4;
        tick();
        headx("bp_drain_4", ov8, om8, m4, 1);
        istream_val = 1'b0;
        tick();
        empty8("bp_empty");

        // Full-rate streaming
        for (int i = 0; i < 20; i++) begin
            send("fr", FR_D[i % 7], 100 + i, FR_R[i % 7], 1'b0);
        end
        istream_val = 1'b0;
        tick();
        empty8("fr_drain");

        // Wrap and illegal destinations on N=5, id=4
        send("wrap_d0", 0, 60, 1, 1'b1);
        send("wrap_d2", 2, 61, 2, 1'b1);
        send("wrap_d6", 6, 62, 0, 1'b1);
        istream_val = 1'b0;
        tick();
        chk("wrap_drain", wide_t'(ov5), wide_t'(3'b000));

        // Reset mid-operation with two stalled entries
        ostream_rdy = 3'b000;
        m1 = mk(5, 70); m2 = mk(5, 71);
        istream_msg = m1; istream_val = 1'b1;
        tick();
        istream_msg = m2;
        tick();
        istream_val = 1'b0;
        headx("mr_head", ov8, om8, m1, 1);
        chk("mr_full", wide_t'(rdy8), wide_t'(1'b0));
        #3 reset_n = 1'b0;
        #1;
        empty8("mr_async");
        chk("mr_async_val5", wide_t'(ov5), wide_t'(3'b000));
        chk("mr_async_rdy", wide_t'(rdy8), wide_t'(1'b0));
        ostream_rdy = 3'b111;
        tick();
        #2 reset_n = 1'b1;
        #1;
        chk("mr_rel_rdy", wide_t'(rdy8), wide_t'(1'b0));
        tick();
        chk("mr_edge_rdy", wide_t'(rdy8), wide_t'(1'b1));
        empty8("mr_no_stale_0");
        tick();
        empty8("mr_no_stale_1");
        send("mr_post", 2, 80, 0, 1'b0);
        istream_val = 1'b0;
        tick();
        empty8("mr_post_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
